// File: rtl/circle_engine.sv
// Midpoint circle rasteriser feeding the VGA adapter pixel port: outline or filled
// disc, one pixel candidate per clock, clipped against an XMAX x YMAX screen.
module circle_engine #(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int RW   = 8,
  parameter int CW   = 3,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fill,
  input  logic [XW-1:0] centre_x,
  input  logic [YW-1:0] centre_y,
  input  logic [RW-1:0] radius,
  input  logic [CW-1:0] colour,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);
  localparam int MW = (XW > YW) ? XW : YW;
  localparam int AW = ((MW > RW) ? MW : RW) + 2;
  localparam logic signed [AW-1:0] ONE  = AW'(1);
  localparam logic signed [AW-1:0] ZERO = '0;
  localparam logic signed [AW-1:0] XLIM = AW'(XMAX);
  localparam logic signed [AW-1:0] YLIM = AW'(YMAX);

  typedef enum logic [1:0] {IDLE, OCT, SPAN, DONE} state_t;

  state_t               r_state, w_state_n;
  logic signed [AW-1:0] r_cx, r_cy, r_ox, r_oy, r_crit, r_dx;
  logic signed [AW-1:0] w_cx_n, w_cy_n, w_ox_n, w_oy_n, w_crit_n, w_dx_n;
  logic [2:0]           r_k, w_k_n;
  logic [1:0]           r_s, w_s_n;
  logic [CW-1:0]        r_colour, w_colour_n;

  logic signed [AW-1:0] w_cx_in, w_cy_in, w_r_in;
  logic signed [AW-1:0] w_oy_step, w_ox_dec, w_ox_step, w_crit_step;
  logic signed [AW-1:0] w_half, w_next_half, w_px, w_py;
  logic                 w_crit_le0, w_cont, w_span_last, w_on, w_active;

  assign w_cx_in = $signed({{(AW-XW){1'b0}}, centre_x});
  assign w_cy_in = $signed({{(AW-YW){1'b0}}, centre_y});
  assign w_r_in  = $signed({{(AW-RW){1'b0}}, radius});

  // Midpoint step, using the already-incremented oy (and decremented ox).
  assign w_oy_step   = r_oy + ONE;
  assign w_ox_dec    = r_ox - ONE;
  assign w_crit_le0  = (r_crit <= ZERO);
  assign w_ox_step   = w_crit_le0 ? r_ox : w_ox_dec;
  assign w_crit_step = w_crit_le0 ? (r_crit + (w_oy_step <<< 1) + ONE)
                                  : (r_crit + ((w_oy_step - w_ox_dec) <<< 1) + ONE);
  assign w_cont      = (w_oy_step <= w_ox_step);

  // Spans 0/1 cover +-ox, spans 2/3 cover +-oy; r_dx walks the current span.
  assign w_half      = r_s[1] ? r_oy : r_ox;
  assign w_next_half = (r_s == 2'd0) ? r_ox : r_oy;
  assign w_span_last = (r_dx == w_half);

  always_comb begin
    w_px = r_cx + r_dx;
    w_py = r_cy + r_oy;
    if (r_state == OCT) begin
      case (r_k)
        3'd0:    begin w_px = r_cx + r_ox; w_py = r_cy + r_oy; end
        3'd1:    begin w_px = r_cx + r_oy; w_py = r_cy + r_ox; end
        3'd2:    begin w_px = r_cx - r_oy; w_py = r_cy + r_ox; end
        3'd3:    begin w_px = r_cx - r_ox; w_py = r_cy + r_oy; end
        3'd4:    begin w_px = r_cx - r_ox; w_py = r_cy - r_oy; end
        3'd5:    begin w_px = r_cx - r_oy; w_py = r_cy - r_ox; end
        3'd6:    begin w_px = r_cx + r_oy; w_py = r_cy - r_ox; end
        default: begin w_px = r_cx + r_ox; w_py = r_cy - r_oy; end
      endcase
    end else begin
      case (r_s)
        2'd0:    w_py = r_cy + r_oy;
        2'd1:    w_py = r_cy - r_oy;
        2'd2:    w_py = r_cy + r_ox;
        default: w_py = r_cy - r_ox;
      endcase
    end
  end

  assign w_on     = !w_px[AW-1] && (w_px < XLIM) && !w_py[AW-1] && (w_py < YLIM);
  assign w_active = (r_state == OCT) || (r_state == SPAN);

  assign vga_plot   = w_active && w_on;
  assign vga_x      = w_active ? w_px[XW-1:0] : '0;
  assign vga_y      = w_active ? w_py[YW-1:0] : '0;
  assign vga_colour = r_colour;
  assign done       = (r_state == DONE);

  always_comb begin
    w_state_n  = r_state;
    w_cx_n     = r_cx;
    w_cy_n     = r_cy;
    w_ox_n     = r_ox;
    w_oy_n     = r_oy;
    w_crit_n   = r_crit;
    w_dx_n     = r_dx;
    w_k_n      = r_k;
    w_s_n      = r_s;
    w_colour_n = r_colour;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_cx_n     = w_cx_in;
          w_cy_n     = w_cy_in;
          w_colour_n = colour;
          w_ox_n     = w_r_in;
          w_oy_n     = ZERO;
          w_crit_n   = ONE - w_r_in;
          w_dx_n     = -w_r_in;
          w_k_n      = 3'd0;
          w_s_n      = 2'd0;
          w_state_n  = fill ? SPAN : OCT;
        end
      end
      OCT: begin
        w_k_n = r_k + 3'd1;
        if (r_k == 3'd7) begin
          w_oy_n    = w_oy_step;
          w_ox_n    = w_ox_step;
          w_crit_n  = w_crit_step;
          w_state_n = w_cont ? OCT : DONE;
        end
      end
      SPAN: begin
        if (!w_span_last) begin
          w_dx_n = r_dx + ONE;
        end else if (r_s == 2'd3) begin
          w_oy_n    = w_oy_step;
          w_ox_n    = w_ox_step;
          w_crit_n  = w_crit_step;
          w_dx_n    = -w_ox_step;
          w_s_n     = 2'd0;
          w_state_n = w_cont ? SPAN : DONE;
        end else begin
          w_s_n  = r_s + 2'd1;
          w_dx_n = -w_next_half;
        end
      end
      default: begin
        if (!start) w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_crit   <= '0;
      r_dx     <= '0;
      r_k      <= '0;
      r_s      <= '0;
      r_colour <= '0;
    end else begin
      r_state  <= w_state_n;
      r_cx     <= w_cx_n;
      r_cy     <= w_cy_n;
      r_ox     <= w_ox_n;
      r_oy     <= w_oy_n;
      r_crit   <= w_crit_n;
      r_dx     <= w_dx_n;
      r_k      <= w_k_n;
      r_s      <= w_s_n;
      r_colour <= w_colour_n;
    end
  end

endmodule

// File: doc/circle_engine.md
# circle_engine

Parametrised midpoint (Bresenham) circle rasteriser that drives the VGA adapter's pixel-write port directly. It draws either an outline or a filled disc of a given centre, radius and colour, one pixel per clock, and clips against a configurable screen size. It sits between the top-level lab wrapper (start/colour/geometry from switches or a sequencer) and the VGA adapter's x/y/colour/plot inputs. It replaces the fixed 160x120 outline-only circle drawer.

## Interface
- XW, 8, width of x coordinate buses
- YW, 7, width of y coordinate buses
- RW, 8, width of radius input
- CW, 3, width of colour bus
- XMAX, 160, screen width; valid x is 0..XMAX-1
- YMAX, 120, screen height; valid y is 0..YMAX-1

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level request; sampled only in IDLE
- fill  in  1  0 = outline, 1 = filled disc; latched at start
- centre_x  in  XW  circle centre x; latched at start
- centre_y  in  YW  circle centre y; latched at start
- radius  in  RW  radius; latched at start
- colour  in  CW  pixel colour; latched at start
- done  out  1  run complete; held until start drops
- vga_x  out  XW  pixel x (low XW bits of computed coordinate)
- vga_y  out  YW  pixel y (low YW bits)
- vga_colour  out  CW  latched colour
- vga_plot  out  1  write strobe; high only for on-screen pixels

## Operation
- States: IDLE, OCT (outline), SPAN (fill), DONE.
- IDLE: start=1 sampled -> latch inputs; oy=0, ox=radius, crit=1-radius; go to OCT if fill=0 else SPAN.
- Loop condition: continue while oy <= ox (signed); on failure go to DONE instead of plotting.
- OCT: 8 cycles per iteration, octant index k=0..7 emits (cx+ox,cy+oy),(cx+oy,cy+ox),(cx-oy,cy+ox),(cx-ox,cy+oy),(cx-ox,cy-oy),(cx-oy,cy-ox),(cx+oy,cy-ox),(cx+ox,cy-oy). Duplicates (oy=0 or oy=ox) are emitted, not removed.
- SPAN: per iteration 4 horizontal spans in order: row cy+oy and cy-oy over x=cx-ox..cx+ox; row cy+ox and cy-ox over x=cx-oy..cx+oy; left to right, one pixel per cycle. Iteration length 2(2ox+1)+2(2oy+1) cycles.
- Step on last pixel cycle of an iteration: oy+=1; if crit<=0 crit+=2*oy+1 else {ox-=1; crit+=2*(oy-ox)+1} (updated values).
- Arithmetic: signed, width max(XW,YW,RW)+2; no overflow for any legal input.
- Clipping: pixel with x<0, x>=XMAX, y<0 or y>=YMAX still consumes its cycle; vga_plot=0 for it.
- DONE: done=1, vga_plot=0; stays until start=0 sampled, then IDLE. Holding start high never retriggers.
- Input changes after latch are ignored until next run.

## Timing
- Reset (async, immediate): state IDLE, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- Outputs are registered from state; start sampled at edge E -> first pixel valid in cycle after E.
- Exactly one pixel candidate per cycle in OCT/SPAN; no bubbles between octants, spans or iterations.
- Last pixel cycle at edge L -> done=1 from L; vga_plot=0 from L.
- Total cycles (outline) = 8 * iterations; fill = sum of iteration lengths.
- rst asserted mid-run: abort immediately, no further plots, done=0; deassert -> IDLE, needs fresh start.
- radius=0 is legal: one iteration.

## Test plan
- Outline, centre (80,60), r=1, colour 3: exactly 16 plot cycles (2 iterations, 8 each), coords only from {79,80,81}x{59,60,61}, colour 3; done rises next cycle, held until start=0.
- Outline r=0 centre (10,10): 8 plot cycles all at (10,10), then done; fill r=0: 4 plots at (10,10).
- Fill, centre (80,60), r=5: union of plotted pixels equals reference disc set (every pixel with midpoint rule inside), zero pixels outside; cycle count matches span formula.
- Clipping, centre (0,0), r=10, outline: vga_plot=0 whenever computed x<0 or y<0; cycle count identical to unclipped case at (80,60).
- Reset mid-run: assert rst on 5th plot cycle -> vga_plot=0 and done=0 same cycle; after release with start held high, new run starts from IDLE with freshly latched inputs.
- Start held high across done: no second run; changing radius during run has no effect on output.
